// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: pipeline-side handshake between the hazard controller and the interrupt sequencer
interface interrupt_sequencer_if #(parameter int PC_W = 10);
  logic            int_set;
  logic            int_clr;
  logic            retie;
  logic [PC_W-1:0] pc_next;
  logic            branch_taken;
  logic            pc_stall;
  logic            int_en;
  logic            int_pending;
  logic            busy;
  logic            flush;
  logic            fetch_hold;
  logic            ret_addr_we;
  logic [PC_W-1:0] ret_addr;
  logic            flags_save;
  logic            vec_load;
  logic [PC_W-1:0] vec_addr;
  modport master (
    output int_set, int_clr, retie, pc_next, branch_taken, pc_stall,
    input  int_en, int_pending, busy, flush, fetch_hold, ret_addr_we, ret_addr, flags_save, vec_load, vec_addr
  );
  modport slave (
    input  int_set, int_clr, retie, pc_next, branch_taken, pc_stall,
    output int_en, int_pending, busy, flush, fetch_hold, ret_addr_we, ret_addr, flags_save, vec_load, vec_addr
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: latches external interrupts and drives the ACK/SAVE/VECTOR ISR entry sequence
module interrupt_sequencer #(
  parameter int              PC_W        = 10,
  parameter logic [PC_W-1:0] VECTOR_ADDR = 10'h3FF,
  parameter int              SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   interrupt,
  interrupt_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACK, SAVE, VECTOR} state_t;
  state_t                 state;
  logic [SYNC_STAGES:0]   sync;
  logic                   rise_q;
  logic                   accept;
  // A CLI retiring in the accept cycle must win, so int_clr blocks entry
  assign accept = state == IDLE && bus.int_pending && bus.int_en && !bus.pc_stall &&
                  !bus.branch_taken && !bus.int_clr;
  assign bus.vec_addr = VECTOR_ADDR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sync            <= '0;
      rise_q          <= 1'b0;
      bus.int_pending <= 1'b0;
      bus.int_en      <= 1'b0;
      bus.ret_addr    <= '0;
      bus.busy        <= 1'b0;
      bus.flush       <= 1'b0;
      bus.fetch_hold  <= 1'b0;
      bus.ret_addr_we <= 1'b0;
      bus.flags_save  <= 1'b0;
      bus.vec_load    <= 1'b0;
    end else begin
      sync            <= {sync[SYNC_STAGES-1:0], interrupt};
      rise_q          <= sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES];
      // a fresh edge during the sequence re-arms the request for after return
      bus.int_pending <= rise_q | (bus.int_pending & ~accept);
      bus.int_en      <= (accept || bus.int_clr) ? 1'b0 :
                         (state == IDLE && (bus.int_set || bus.retie)) ? 1'b1 : bus.int_en;
      if (accept) bus.ret_addr <= bus.pc_next;
      case (state)
        IDLE:    state <= accept ? ACK : IDLE;
        ACK:     state <= SAVE;
        SAVE:    state <= VECTOR;
        default: state <= IDLE;
      endcase
      bus.busy        <= accept || state == ACK || state == SAVE;
      bus.flush       <= accept || state == ACK || state == SAVE;
      bus.fetch_hold  <= accept || state == ACK;
      bus.ret_addr_we <= state == ACK;
      bus.flags_save  <= state == ACK;
      bus.vec_load    <= state == SAVE;
    end
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed and randomized checks against a cycle-level behavioural model
module tb_interrupt_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic interrupt = 1'b0;
  interrupt_sequencer_if #(.PC_W(10)) bus();
  interrupt_sequencer #(.PC_W(10), .VECTOR_ADDR(10'h3FF), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .bus(bus)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int       m_phase = 0;
  bit       m_en = 1'b0;
  bit       m_pend = 1'b0;
  bit [9:0] m_ret = '0;
  bit       hist [4] = '{default: 1'b0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit accept_now();
    return m_phase == 0 && m_pend && m_en && !bus.pc_stall && !bus.branch_taken && !bus.int_clr;
  endfunction
  // model: request lands 3 edges after the sample that first saw the line high
  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_en    <= 1'b0;
      m_pend  <= 1'b0;
      m_ret   <= '0;
      hist    <= '{default: 1'b0};
      chk_en  <= 1'b1;
    end else begin
      m_en    <= (accept_now() || bus.int_clr) ? 1'b0 :
                 (m_phase == 0 && (bus.int_set || bus.retie)) ? 1'b1 : m_en;
      m_pend  <= (hist[2] && !hist[3]) || (m_pend && !accept_now());
      if (accept_now()) m_ret <= bus.pc_next;
      m_phase <= accept_now() ? 1 : (m_phase == 0 ? 0 : (m_phase + 1) % 4);
      hist    <= '{interrupt, hist[0], hist[1], hist[2]};
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("int_en", bus.int_en, m_en);
      chk("int_pending", bus.int_pending, m_pend);
      chk("busy", bus.busy, m_phase != 0);
      chk("flush", bus.flush, m_phase != 0);
      chk("fetch_hold", bus.fetch_hold, m_phase == 1 || m_phase == 2);
      chk("ret_addr_we", bus.ret_addr_we, m_phase == 2);
      chk("flags_save", bus.flags_save, m_phase == 2);
      chk("vec_load", bus.vec_load, m_phase == 3);
      chk("ret_addr", bus.ret_addr, m_ret);
      chk("vec_addr", bus.vec_addr, 10'h3FF);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sei();
    bus.int_set = 1'b1;
    tick();
    bus.int_set = 1'b0;
  endtask
  task automatic wait_pend(input string name);
    for (int i = 0; i < 12 && !bus.int_pending; i++) tick();
    chk(name, bus.int_pending, 1);
  endtask
  task automatic pulse();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
  endtask
  initial begin
    int n;
    int busy_cnt;
    bus.int_set = 0; bus.int_clr = 0; bus.retie = 0; bus.pc_next = '0;
    bus.branch_taken = 0; bus.pc_stall = 0;
    tick(); tick();
    chk("rst_int_en", bus.int_en, 0);
    chk("rst_pending", bus.int_pending, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ret_addr", bus.ret_addr, 0);
    reset = 1'b0;
    // basic entry
    bus.pc_next = 10'h045;
    sei();
    chk("sei_en", bus.int_en, 1);
    interrupt = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.int_pending) begin n = i; break; end
    end
    chk("req_latency", n, 4);
    tick();
    chk("ack_busy", bus.busy, 1);
    chk("ack_fetch_hold", bus.fetch_hold, 1);
    chk("ack_int_en", bus.int_en, 0);
    chk("ack_ret_we", bus.ret_addr_we, 0);
    tick();
    chk("save_ret_we", bus.ret_addr_we, 1);
    chk("save_ret_addr", bus.ret_addr, 10'h045);
    tick();
    chk("vec_load", bus.vec_load, 1);
    chk("vec_fetch_hold", bus.fetch_hold, 0);
    tick();
    chk("done_busy", bus.busy, 0);
    chk("done_pending", bus.int_pending, 0);
    interrupt = 1'b0;
    repeat (4) tick();
    // masked request
    pulse();
    repeat (20) tick();
    chk("masked_pending", bus.int_pending, 1);
    chk("masked_busy", bus.busy, 0);
    sei();
    chk("sei_edge_busy", bus.busy, 0);
    tick();
    chk("masked_ack", bus.busy, 1);
    repeat (4) tick();
    // hazard deferral
    sei();
    bus.pc_stall = 1'b1;
    pulse();
    wait_pend("haz_pending");
    repeat (3) begin tick(); chk("stall_busy", bus.busy, 0); end
    bus.pc_stall = 1'b0; bus.branch_taken = 1'b1;
    tick();
    chk("branch_flush", bus.flush, 0);
    bus.branch_taken = 1'b0;
    tick();
    chk("haz_ack", bus.busy, 1);
    repeat (4) tick();
    // CLI race
    sei();
    bus.pc_stall = 1'b1;
    pulse();
    wait_pend("cli_pending_pre");
    bus.pc_stall = 1'b0; bus.int_clr = 1'b1;
    tick();
    bus.int_clr = 1'b0;
    chk("cli_busy", bus.busy, 0);
    chk("cli_int_en", bus.int_en, 0);
    chk("cli_pending", bus.int_pending, 1);
    bus.int_set = 1'b1; bus.int_clr = 1'b1;
    tick();
    bus.int_set = 1'b0; bus.int_clr = 1'b0;
    chk("setclr_int_en", bus.int_en, 0);
    // reset mid-sequence
    sei();
    tick();
    tick();
    chk("pre_rst_save", bus.ret_addr_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pending", bus.int_pending, 0);
    chk("mid_rst_int_en", bus.int_en, 0);
    chk("mid_rst_strobes", {bus.flush, bus.fetch_hold, bus.ret_addr_we, bus.flags_save, bus.vec_load}, 0);
    chk("mid_rst_ret_addr", bus.ret_addr, 0);
    repeat (4) tick();
    // re-arm with a second edge during the sequence
    sei();
    interrupt = 1'b1;
    wait_pend("rearm_pending1");
    tick();
    chk("rearm_ack1", bus.busy, 1);
    interrupt = 1'b0;
    tick();
    interrupt = 1'b1;
    repeat (6) tick();
    chk("rearm_pending2", bus.int_pending, 1);
    chk("rearm_idle", bus.busy, 0);
    bus.retie = 1'b1;
    tick();
    bus.retie = 1'b0;
    chk("retie_en", bus.int_en, 1);
    tick();
    chk("rearm_ack2", bus.busy, 1);
    repeat (4) tick();
    bus.retie = 1'b1;
    tick();
    bus.retie = 1'b0;
    busy_cnt = 0;
    repeat (12) begin tick(); busy_cnt += bus.busy; end
    chk("no_third_entry", busy_cnt, 0);
    interrupt = 1'b0;
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset            = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) interrupt = ~interrupt;
      bus.int_set      = ($urandom_range(0, 7) == 0);
      bus.int_clr      = ($urandom_range(0, 15) == 0);
      bus.retie        = ($urandom_range(0, 9) == 0);
      bus.pc_stall     = ($urandom_range(0, 3) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.pc_next      = 10'($urandom);
      tick();
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
